// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate between N_MGR managers.
// Responses are routed back through an in-order ID FIFO; spurious responses are counted.
module obi_rr_arbiter #(
    parameter int N_MGR   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_MGR-1:0]          mgr_req_i,
    output logic [N_MGR-1:0]          mgr_gnt_o,
    input  logic [N_MGR*ADDR_W-1:0]   mgr_addr_i,
    input  logic [N_MGR-1:0]          mgr_we_i,
    input  logic [N_MGR*DATA_W/8-1:0] mgr_be_i,
    input  logic [N_MGR*DATA_W-1:0]   mgr_wdata_i,
    output logic [N_MGR-1:0]          mgr_rvalid_o,
    output logic [DATA_W-1:0]         mgr_rdata_o,
    output logic [N_MGR-1:0]          mgr_err_o,
    output logic                      sbr_req_o,
    input  logic                      sbr_gnt_i,
    output logic [ADDR_W-1:0]         sbr_addr_o,
    output logic                      sbr_we_o,
    output logic [DATA_W/8-1:0]       sbr_be_o,
    output logic [DATA_W-1:0]         sbr_wdata_o,
    input  logic                      sbr_rvalid_i,
    input  logic [DATA_W-1:0]         sbr_rdata_i,
    input  logic                      sbr_err_i,
    output logic [7:0]                err_cnt_o
);

    localparam int IDX_W = $clog2(N_MGR);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;
    localparam int BE_W  = DATA_W / 8;

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] locked_idx_q, locked_idx_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] id_mem_q [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0] winner, cand, head;
    logic             full, empty, lock_drop, handshake, push, pop, spurious;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == N_MGR - 1) ? '0 : i + 1'b1;
    endfunction

    assign full  = (int'(count_q) == MAX_OUT);
    assign empty = (count_q == '0);
    assign head  = id_mem_q[rd_ptr_q];

    // Descending scan so the candidate closest to the rr pointer is assigned last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        winner = rr_q;
        cand   = '0;
        if (lock_q) begin
            winner = locked_idx_q;
        end else begin
            for (int i = N_MGR - 1; i >= 0; i--) begin
                cand = IDX_W'((int'(rr_q) + i) % N_MGR);
                if (mgr_req_i[cand]) winner = cand;
            end
        end
    end

    // A locked manager that withdraws its request must not be granted on someone else's behalf.
    assign lock_drop = lock_q & ~mgr_req_i[locked_idx_q];
    assign sbr_req_o = (|mgr_req_i) & ~lock_drop & ~full;
    assign handshake = sbr_req_o & sbr_gnt_i;
    assign push      = handshake;
    assign pop       = sbr_rvalid_i & ~empty;
    assign spurious  = sbr_rvalid_i & empty;

    always_comb begin
        sbr_addr_o  = '0;
        sbr_we_o    = 1'b0;
        sbr_be_o    = '0;
        sbr_wdata_o = '0;
        mgr_gnt_o   = '0;
        if (sbr_req_o) begin
            sbr_addr_o  = mgr_addr_i[winner*ADDR_W +: ADDR_W];
            sbr_we_o    = mgr_we_i[winner];
            sbr_be_o    = mgr_be_i[winner*BE_W +: BE_W];
            sbr_wdata_o = mgr_wdata_i[winner*DATA_W +: DATA_W];
        end
        mgr_gnt_o[winner] = handshake;
    end

    always_comb begin
        mgr_rvalid_o = '0;
        mgr_err_o    = '0;
        if (pop) begin
            mgr_rvalid_o[head] = 1'b1;
            mgr_err_o[head]    = sbr_err_i;
        end
    end

    assign mgr_rdata_o = sbr_rdata_i;
    assign err_cnt_o   = err_cnt_q;

    always_comb begin
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        rr_d         = rr_q;
        if (lock_drop) begin
            lock_d = 1'b0;
        end else if (sbr_req_o && !sbr_gnt_i) begin
            lock_d       = 1'b1;
            locked_idx_d = winner;
        end else if (handshake) begin
            lock_d = 1'b0;
        end
        if (handshake) rr_d = idx_inc(winner);
    end

    always_comb begin
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (spurious && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_cnt_q    <= '0;
        end else begin
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // NOTE: the ID storage is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clk_i) begin
        if (push) id_mem_q[wr_ptr_q] <= winner;
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter (N_MGR=2, MAX_OUT=2) with an ID scoreboard.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_obi_rr_arbiter;

    localparam int N_MGR   = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N_MGR-1:0]  mgr_req_i;
    logic [N_MGR-1:0]  mgr_gnt_o;
    logic [N_MGR*ADDR_W-1:0]   mgr_addr_i;
    logic [N_MGR-1:0]          mgr_we_i;
    logic [N_MGR*DATA_W/8-1:0] mgr_be_i;
    logic [N_MGR*DATA_W-1:0]   mgr_wdata_i;
    logic [N_MGR-1:0]  mgr_rvalid_o;
    logic [DATA_W-1:0] mgr_rdata_o;
    logic [N_MGR-1:0]  mgr_err_o;
    logic              sbr_req_o;
    logic              sbr_gnt_i;
    logic [ADDR_W-1:0] sbr_addr_o;
    logic              sbr_we_o;
    logic [DATA_W/8-1:0] sbr_be_o;
    logic [DATA_W-1:0] sbr_wdata_o;
    logic              sbr_rvalid_i;
    logic [DATA_W-1:0] sbr_rdata_i;
    logic              sbr_err_i;
    logic [7:0]        err_cnt_o;

    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    assign mgr_addr_i  = {addr1, addr0};
    assign mgr_wdata_i = {wdata1, wdata0};

    always #5 clk_i = ~clk_i;

    obi_rr_arbiter #(
        .N_MGR(N_MGR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
        .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
        .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
        .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o),
        .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
        .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i),
        .err_cnt_o(err_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rvalid,
                         input logic [DATA_W-1:0] rdata, input logic err);
        mgr_req_i    = req;
        sbr_gnt_i    = gnt;
        sbr_rvalid_i = rvalid;
        sbr_rdata_i  = rdata;
        sbr_err_i    = err;
    endtask

    // Pops the oldest issued manager ID and checks that the response is routed to it.
    task automatic expect_resp(input string tag, input logic [DATA_W-1:0] rdata, input logic err);
        int id;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            id = exp_q.pop_front();
            check({tag, "_rvalid"}, mgr_rvalid_o, 64'(1) << id);
            check({tag, "_err"}, mgr_err_o, err ? (64'(1) << id) : 64'(0));
            check({tag, "_rdata"}, mgr_rdata_o, rdata);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mgr_we_i = '0; mgr_be_i = '0;
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();

        // Reset then idle
        @(negedge clk_i);
        check("rst_err_cnt", err_cnt_o, 0);
        check("rst_sbr_req", sbr_req_o, 0);
        check("rst_gnt", mgr_gnt_o, 0);
        check("rst_rvalid", mgr_rvalid_o, 0);

        // Single read from mgr0, response one cycle later
        tick();
        addr0 = 32'h0000_0003;
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("rd0_gnt", mgr_gnt_o, 2'b01);
        check("rd0_addr", sbr_addr_o, 32'h0000_0003);
        exp_q.push_back(0);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_3333, 1'b0);
        @(negedge clk_i);
        expect_resp("rd0", 32'h0000_3333, 1'b0);

        // Single read from mgr1; leaves rr pointer at mgr0
        tick();
        addr1 = 32'h0000_0011;
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("rd1_gnt", mgr_gnt_o, 2'b10);
        check("rd1_addr", sbr_addr_o, 32'h0000_0011);
        exp_q.push_back(1);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_1111, 1'b0);
        @(negedge clk_i);
        expect_resp("rd1", 32'h0000_1111, 1'b0);

        // Contention: both request, grants alternate starting at mgr0
        addr0 = 32'h0000_00A0; addr1 = 32'h0000_00B1;
        wdata0 = 32'hAAAA_0000; wdata1 = 32'hBBBB_1111;
        mgr_we_i = 2'b10; mgr_be_i = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(2'b11, 1'b1, k > 0, 32'h100 + k, 1'b0);
            @(negedge clk_i);
            if (k > 0) expect_resp("cont", 32'h100 + k, 1'b0);
            check("cont_gnt", mgr_gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("cont_addr", sbr_addr_o, (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1);
            check("cont_we", sbr_we_o, (k % 2 == 0) ? 1'b0 : 1'b1);
            check("cont_be", sbr_be_o, (k % 2 == 0) ? 4'h3 : 4'hC);
            check("cont_wdata", sbr_wdata_o, (k % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_1111);
            exp_q.push_back(k % 2);
        end
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h104, 1'b0);
        @(negedge clk_i);
        expect_resp("cont_last", 32'h104, 1'b0);
        mgr_we_i = '0;

        // Stall lock: mgr1 stalled, mgr0 joins; rr favours mgr0 but mgr1 stays locked
        for (int c = 0; c < 3; c++) begin
            tick();
            drive((c == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, '0, 1'b0);
            @(negedge clk_i);
            check("lock_req", sbr_req_o, 1);
            check("lock_gnt", mgr_gnt_o, 2'b00);
            check("lock_addr", sbr_addr_o, 32'h0000_00B1);
        end
        tick();
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("lock_release_gnt", mgr_gnt_o, 2'b10);
        check("lock_release_addr", sbr_addr_o, 32'h0000_00B1);
        exp_q.push_back(1);
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'h0000_E001, 1'b1);
        @(negedge clk_i);
        expect_resp("lock_resp_err", 32'h0000_E001, 1'b1);
        check("lock_next_gnt", mgr_gnt_o, 2'b01);
        exp_q.push_back(0);
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_E002, 1'b0);
        @(negedge clk_i);
        expect_resp("lock_resp", 32'h0000_E002, 1'b0);

        // FIFO full: two outstanding, third request stalls until a pop has registered
        for (int c = 0; c < 2; c++) begin
            tick();
            drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
            @(negedge clk_i);
            check("fill_gnt", mgr_gnt_o, 2'b01);
            exp_q.push_back(0);
        end
        tick();
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("full_req", sbr_req_o, 0);
        check("full_gnt", mgr_gnt_o, 2'b00);
        tick();
        drive(2'b01, 1'b1, 1'b1, 32'h0000_00F0, 1'b0);
        @(negedge clk_i);
        expect_resp("full_pop", 32'h0000_00F0, 1'b0);
        check("full_pop_req", sbr_req_o, 0);
        check("full_pop_gnt", mgr_gnt_o, 2'b00);
        tick();
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("after_pop_req", sbr_req_o, 1);
        check("after_pop_gnt", mgr_gnt_o, 2'b01);
        exp_q.push_back(0);
        for (int c = 0; c < 2; c++) begin
            tick();
            drive(2'b00, 1'b0, 1'b1, 32'h0000_00F1 + c, 1'b0);
            @(negedge clk_i);
            expect_resp("drain", 32'h0000_00F1 + c, 1'b0);
        end

        // Spurious rvalid with nothing outstanding; count saturates at 0xFF
        for (int k = 0; k < 300; k++) begin
            tick();
            drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
            @(negedge clk_i);
            check("spur_rvalid", mgr_rvalid_o, 0);
            check("spur_err_cnt", err_cnt_o, (k > 255) ? 255 : k);
        end
        tick();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("spur_sat", err_cnt_o, 8'hFF);

        // Reset mid-transaction discards the outstanding ID
        tick();
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("mid_gnt", mgr_gnt_o, 2'b01);
        tick();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("async_rst_err_cnt", err_cnt_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h0000_5555, 1'b0);
        @(negedge clk_i);
        check("post_rst_rvalid", mgr_rvalid_o, 0);
        tick();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk_i);
        check("post_rst_err_cnt", err_cnt_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
